// File: rtl/burst_ram_responder_pkg.sv
// Shared types and sizing helpers for the burst bus RAM responder.
// Index and bounds-check widths are derived from the RAM depth.
package burst_ram_responder_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    READ_SETUP = 3'd2,
    READ_BURST = 3'd3,
    READ_END   = 3'd4,
    ERROR_WAIT = 3'd5
  } respState_t;

  localparam int BUS_WIDTH        = 32;
  localparam int BE_WIDTH         = 4;
  localparam int BYTE_OFFSET_BITS = 2;
  localparam int BURST_WIDTH      = 8;
  localparam int COUNT_WIDTH      = BURST_WIDTH + 1;

  function automatic int indexWidth(input int words);
    return $clog2(words);
  endfunction

  // Wide enough that index + burstSizeIn never overflows before the compare.
  function automatic int boundsWidth(input int words);
    return $clog2(words) + BURST_WIDTH + 1;
  endfunction

endpackage

// File: rtl/burst_ram_responder_byte_enable_ram.sv
// Single-port synchronous RAM with per-byte write enables and one cycle of
// read latency; contents are never cleared.
module byte_enable_ram
  import burst_ram_responder_pkg::*;
#(
  parameter int depth     = 1024,
  parameter int addrWidth = indexWidth(depth)
) (
  input  logic                 i_clock,
  input  logic [addrWidth-1:0] i_address,
  input  logic [BUS_WIDTH-1:0] i_writeData,
  input  logic [BE_WIDTH-1:0]  i_byteWrite,
  output logic [BUS_WIDTH-1:0] o_readData
);

  logic [BUS_WIDTH-1:0] r_mem [depth];

  // Read returns the pre-write word when the same address is written.
  always_ff @(posedge i_clock) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (i_byteWrite[b]) begin
        r_mem[i_address][b*8 +: 8] <= i_writeData[b*8 +: 8];
      end
    end
    o_readData <= r_mem[i_address];
  end

endmodule

// File: rtl/burst_ram_responder.sv
// Burst bus target: decodes begin cycles for its region, accepts byte-enabled
// write bursts into local RAM and streams read bursts back.
module burst_ram_responder
  import burst_ram_responder_pkg::*;
#(
  parameter logic [BUS_WIDTH-1:0] baseAddress     = 32'h0000_0000,
  parameter int                   sizeInWords     = 1024,
  parameter int                   writeWaitStates = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   beginTransactionIn,
  input  logic [BUS_WIDTH-1:0]   addressDataIn,
  input  logic                   endTransactionIn,
  input  logic [BE_WIDTH-1:0]    byteEnablesIn,
  input  logic                   dataValidIn,
  input  logic [BURST_WIDTH-1:0] burstSizeIn,
  input  logic                   readNotWriteIn,
  output logic [BUS_WIDTH-1:0]   addressDataOut,
  output logic                   dataValidOut,
  output logic                   endTransactionOut,
  output logic                   busyOut,
  output logic                   busErrorOut
);

  localparam int IDX_W   = indexWidth(sizeInWords);
  localparam int BND_W   = boundsWidth(sizeInWords);
  localparam int TAG_LSB = IDX_W + BYTE_OFFSET_BITS;
  localparam logic [BND_W-1:0] LAST_INDEX = BND_W'(sizeInWords - 1);
  localparam logic [2:0]       WAIT_LOAD  = 3'(writeWaitStates);

  respState_t r_state;
  respState_t w_nextState;

  logic [IDX_W-1:0]       r_index;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [BE_WIDTH-1:0]    r_byteEnables;
  logic [2:0]             r_waitCount;
  logic                   r_busError;

  logic                   w_hit;
  logic                   w_beginHit;
  logic                   w_beginError;
  logic                   w_writeBeat;
  logic [IDX_W-1:0]       w_beginIndex;
  logic [BND_W-1:0]       w_lastIndex;
  logic [BUS_WIDTH-1:0]   w_ramData;
  logic [BE_WIDTH-1:0]    w_ramWrite;

  assign w_hit        = addressDataIn[BUS_WIDTH-1:TAG_LSB] == baseAddress[BUS_WIDTH-1:TAG_LSB];
  assign w_beginIndex = addressDataIn[TAG_LSB-1:BYTE_OFFSET_BITS];
  assign w_lastIndex  = BND_W'(w_beginIndex) + BND_W'(burstSizeIn);
  assign w_beginError = (addressDataIn[BYTE_OFFSET_BITS-1:0] != '0) || (w_lastIndex > LAST_INDEX);
  assign w_beginHit   = (r_state == IDLE) && beginTransactionIn && w_hit;
  // A beat arriving in the reset cycle must not land in RAM.
  assign w_writeBeat  = (r_state == WRITE) && dataValidIn && (r_waitCount == 3'd0)
                        && (r_count != '0) && !reset;
  assign w_ramWrite   = w_writeBeat ? r_byteEnables : '0;

  byte_enable_ram #(
    .depth     (sizeInWords),
    .addrWidth (IDX_W)
  ) u_ram (
    .i_clock     (clock),
    .i_address   (r_index),
    .i_writeData (addressDataIn),
    .i_byteWrite (w_ramWrite),
    .o_readData  (w_ramData)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Bus outputs decode straight from registered state so they drop to zero
  // the cycle after any abort or reset.
  always_comb begin
    w_nextState       = r_state;
    dataValidOut      = 1'b0;
    addressDataOut    = '0;
    endTransactionOut = 1'b0;
    busyOut           = 1'b0;
    busErrorOut       = r_busError;
    case (r_state)
      IDLE: begin
        if (w_beginHit) begin
          if (w_beginError) begin
            w_nextState = ERROR_WAIT;
          end else if (readNotWriteIn) begin
            w_nextState = READ_SETUP;
          end else begin
            w_nextState = WRITE;
          end
        end
      end
      WRITE: begin
        busyOut = (r_waitCount != 3'd0);
        if (endTransactionIn) begin
          w_nextState = IDLE;
        end
      end
      READ_SETUP: begin
        w_nextState = endTransactionIn ? IDLE : READ_BURST;
      end
      READ_BURST: begin
        dataValidOut   = 1'b1;
        addressDataOut = w_ramData;
        if (endTransactionIn) begin
          w_nextState = IDLE;
        end else if (r_count == COUNT_WIDTH'(1)) begin
          w_nextState = READ_END;
        end
      end
      READ_END: begin
        endTransactionOut = 1'b1;
        w_nextState       = IDLE;
      end
      ERROR_WAIT: begin
        if (endTransactionIn) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The RAM address runs one word ahead during reads to cover its latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_index       <= '0;
      r_count       <= '0;
      r_byteEnables <= '0;
      r_waitCount   <= '0;
      r_busError    <= 1'b0;
    end else begin
      r_busError <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_beginHit) begin
            r_index       <= w_beginIndex;
            r_count       <= COUNT_WIDTH'(burstSizeIn) + COUNT_WIDTH'(1);
            r_byteEnables <= byteEnablesIn;
            r_waitCount   <= '0;
            r_busError    <= w_beginError;
          end
        end
        WRITE: begin
          if (w_writeBeat) begin
            r_index     <= r_index + IDX_W'(1);
            r_count     <= r_count - COUNT_WIDTH'(1);
            r_waitCount <= WAIT_LOAD;
          end else if (r_waitCount != 3'd0) begin
            r_waitCount <= r_waitCount - 3'd1;
          end
        end
        READ_SETUP: begin
          r_index <= r_index + IDX_W'(1);
        end
        READ_BURST: begin
          r_index <= r_index + IDX_W'(1);
          r_count <= r_count - COUNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_ram_responder.sv
// Self-checking bench for burst_ram_responder: a bus master driver, a word
// model with a read scoreboard queue, a byte-enable vector table and corner sequences.
module tb_burst_ram_responder;

  localparam logic [31:0] BASE        = 32'h8000_1000;
  localparam int          WORDS       = 1024;
  localparam int          WAIT_STATES = 2;

  logic        clock;
  logic        reset;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic        endTransactionIn;
  logic [3:0]  byteEnablesIn;
  logic        dataValidIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busyOut;
  logic        busErrorOut;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [WORDS];
  logic [31:0] wrBuf [256];
  logic [31:0] expQ [$];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] preload;
    logic [31:0] wdata;
    logic [31:0] expected;
  } beVector_t;

  beVector_t beTable [7];

  burst_ram_responder #(
    .baseAddress     (BASE),
    .sizeInWords     (WORDS),
    .writeWaitStates (WAIT_STATES)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .beginTransactionIn (beginTransactionIn),
    .addressDataIn      (addressDataIn),
    .endTransactionIn   (endTransactionIn),
    .byteEnablesIn      (byteEnablesIn),
    .dataValidIn        (dataValidIn),
    .burstSizeIn        (burstSizeIn),
    .readNotWriteIn     (readNotWriteIn),
    .addressDataOut     (addressDataOut),
    .dataValidOut       (dataValidOut),
    .endTransactionOut  (endTransactionOut),
    .busyOut            (busyOut),
    .busErrorOut        (busErrorOut)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0] be);
    logic [31:0] result;
    result = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) result[b*8 +: 8] = newWord[b*8 +: 8];
    end
    return result;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkQuiet(input string name);
    checkOutput(name, {28'd0, dataValidOut, endTransactionOut, busyOut, busErrorOut}, 32'd0);
    checkOutput({name, "Data"}, addressDataOut, 32'd0);
  endtask

  task automatic applyStimulus(input logic beginTx, input logic [31:0] addrData,
                               input logic endTx, input logic [3:0] be,
                               input logic dataValid, input logic [7:0] burst,
                               input logic rnw);
    beginTransactionIn = beginTx;
    addressDataIn      = addrData;
    endTransactionIn   = endTx;
    byteEnablesIn      = be;
    dataValidIn        = dataValid;
    burstSizeIn        = burst;
    readNotWriteIn     = rnw;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Master holds each beat until busyOut is low; the gap must equal the wait states.
  task automatic writeBurst(input logic [31:0] addr, input int nBeats, input logic [3:0] be);
    int waitCycles;
    int idx;
    idx = int'(addr[11:2]);
    applyStimulus(1'b1, addr, 1'b0, be, 1'b0, 8'(nBeats - 1), 1'b0);
    nextCycle();
    for (int b = 0; b < nBeats; b++) begin
      waitCycles = 0;
      applyStimulus(1'b0, wrBuf[b], 1'b0, 4'h0, 1'b1, 8'd0, 1'b0);
      @(negedge clock);
      while (busyOut && waitCycles < 20) begin
        nextCycle();
        waitCycles++;
        @(negedge clock);
      end
      if (b > 0) checkOutput("writeBusyGap", waitCycles, WAIT_STATES);
      model[idx + b] = mergeBytes(model[idx + b], wrBuf[b], be);
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    waitCycles = 0;
    @(negedge clock);
    while (busyOut && waitCycles < 20) begin
      nextCycle();
      waitCycles++;
      @(negedge clock);
    end
    checkOutput("writeBusyTail", waitCycles, WAIT_STATES);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
  endtask

  // Expected words go to the scoreboard at begin; beats must appear at T+2..T+N+1.
  task automatic readBurst(input logic [31:0] addr, input int nBeats,
                           output logic [31:0] firstWord);
    int idx;
    logic [31:0] expWord;
    idx = int'(addr[11:2]);
    for (int k = 0; k < nBeats; k++) expQ.push_back(model[idx + k]);
    applyStimulus(1'b1, addr, 1'b0, 4'hF, 1'b0, 8'(nBeats - 1), 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    firstWord = 32'd0;
    for (int c = 1; c <= nBeats + 2; c++) begin
      @(negedge clock);
      if (c == 1) begin
        checkQuiet("readSetupQuiet");
      end else if (c <= nBeats + 1) begin
        checkOutput("readValid", 32'(dataValidOut), 32'd1);
        expWord = expQ.pop_front();
        checkOutput("readData", addressDataOut, expWord);
        if (c == 2) firstWord = addressDataOut;
      end else begin
        checkOutput("readEnd", 32'(endTransactionOut), 32'd1);
        checkOutput("readEndValid", 32'(dataValidOut), 32'd0);
      end
      nextCycle();
    end
    @(negedge clock);
    checkQuiet("readAfterEnd");
    nextCycle();
  endtask

  initial begin
    logic [31:0] got;
    int waitCycles;

    beTable[0] = '{BASE + 32'h200, 4'b0101, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'hFFBB_FFDD};
    beTable[1] = '{BASE + 32'h204, 4'b1010, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'hAAFF_CCFF};
    beTable[2] = '{BASE + 32'h208, 4'b0001, 32'h0000_0000, 32'h1234_5678, 32'h0000_0078};
    beTable[3] = '{BASE + 32'h20C, 4'b1000, 32'h0000_0000, 32'h1234_5678, 32'h1200_0000};
    beTable[4] = '{BASE + 32'h210, 4'b0000, 32'h5A5A_5A5A, 32'h1234_5678, 32'h5A5A_5A5A};
    beTable[5] = '{BASE + 32'h214, 4'b1111, 32'h5A5A_5A5A, 32'h1234_5678, 32'h1234_5678};
    beTable[6] = '{BASE + 32'h218, 4'b0110, 32'h0000_0000, 32'hCAFE_F00D, 32'h00FE_F000};

    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    nextCycle();
    nextCycle();
    @(negedge clock);
    checkQuiet("resetState");
    nextCycle();
    reset = 1'b0;
    nextCycle();

    $display("[TB] 4-beat write then read");
    for (int k = 0; k < 4; k++) wrBuf[k] = 32'h1111_1111 * (k + 1);
    writeBurst(BASE + 32'h10, 4, 4'hF);
    readBurst(BASE + 32'h10, 4, got);
    checkOutput("burst4First", got, 32'h1111_1111);

    $display("[TB] byte-enable vector table");
    for (int i = 0; i < 7; i++) begin
      wrBuf[0] = beTable[i].preload;
      writeBurst(beTable[i].addr, 1, 4'hF);
      wrBuf[0] = beTable[i].wdata;
      writeBurst(beTable[i].addr, 1, beTable[i].be);
      readBurst(beTable[i].addr, 1, got);
      checkOutput("beTable", got, beTable[i].expected);
    end

    $display("[TB] 256-beat burst");
    for (int k = 0; k < 256; k++) wrBuf[k] = 32'hA500_0000 + 32'(k);
    writeBurst(BASE + 32'h400, 256, 4'hF);
    readBurst(BASE + 32'h400, 256, got);
    checkOutput("burst256First", got, 32'hA500_0000);

    $display("[TB] last-word boundary and bus errors");
    for (int k = 0; k < 9; k++) wrBuf[k] = 32'hE000_0000 + 32'(k);
    writeBurst(BASE + 32'hFDC, 9, 4'hF);

    applyStimulus(1'b1, BASE + 32'hFDC, 1'b0, 4'hF, 1'b0, 8'd15, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'hBAD0_0000, 1'b0, 4'h0, 1'b1, 8'd0, 1'b0);
    @(negedge clock);
    checkOutput("errWriteBusErr", 32'(busErrorOut), 32'd1);
    checkOutput("errWriteBusy", 32'(busyOut), 32'd0);
    nextCycle();
    @(negedge clock);
    checkQuiet("errWriteHold");
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    readBurst(BASE + 32'hFDC, 9, got);
    checkOutput("errWriteUntouched", got, 32'hE000_0000);

    applyStimulus(1'b1, BASE + 32'h2, 1'b0, 4'hF, 1'b0, 8'd0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    @(negedge clock);
    checkOutput("errReadBusErr", 32'(busErrorOut), 32'd1);
    checkOutput("errReadValid", 32'(dataValidOut), 32'd0);
    nextCycle();
    applyStimulus(1'b1, BASE + 32'h10, 1'b0, 4'hF, 1'b0, 8'd0, 1'b1);
    @(negedge clock);
    checkQuiet("errReadOneShot");
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checkQuiet("errWaitIgnoresBegin");
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);

    $display("[TB] region miss");
    applyStimulus(1'b1, 32'h8000_2010, 1'b0, 4'hF, 1'b0, 8'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 4'h0, 1'b1, 8'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checkQuiet("missWriteQuiet");
      nextCycle();
    end
    applyStimulus(1'b1, 32'h0000_1010, 1'b0, 4'hF, 1'b0, 8'd3, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checkQuiet("missReadQuiet");
      nextCycle();
    end
    readBurst(BASE + 32'h10, 1, got);
    checkOutput("missUntouched", got, 32'h1111_1111);

    $display("[TB] aborted 16-beat read");
    for (int k = 0; k < 16; k++) wrBuf[k] = 32'h5000_0000 + 32'(k);
    writeBurst(BASE + 32'h40, 16, 4'hF);
    for (int k = 0; k < 7; k++) expQ.push_back(model[16 + k]);
    applyStimulus(1'b1, BASE + 32'h40, 1'b0, 4'hF, 1'b0, 8'd15, 1'b1);
    nextCycle();
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1'b0, 32'd0, (c == 8), 4'h0, 1'b0, 8'd0, 1'b0);
      @(negedge clock);
      if (c >= 2 && c <= 8) begin
        got = expQ.pop_front();
        checkOutput("abortBeatValid", 32'(dataValidOut), 32'd1);
        checkOutput("abortBeatData", addressDataOut, got);
      end else if (c >= 9) begin
        checkQuiet("abortQuiet");
      end
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);

    $display("[TB] reset during write");
    applyStimulus(1'b1, BASE + 32'h100, 1'b0, 4'hF, 1'b0, 8'd3, 1'b0);
    nextCycle();
    for (int b = 0; b < 2; b++) begin
      waitCycles = 0;
      applyStimulus(1'b0, 32'hC0DE_0000 + 32'(b), 1'b0, 4'h0, 1'b1, 8'd0, 1'b0);
      @(negedge clock);
      while (busyOut && waitCycles < 20) begin
        nextCycle();
        waitCycles++;
        @(negedge clock);
      end
      model[64 + b] = 32'hC0DE_0000 + 32'(b);
      nextCycle();
    end
    applyStimulus(1'b0, 32'hFEED_FACE, 1'b0, 4'h0, 1'b1, 8'd0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("resetBusyBefore", 32'(busyOut), 32'd1);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    @(negedge clock);
    checkQuiet("resetMidWrite");
    nextCycle();
    readBurst(BASE + 32'h100, 2, got);
    checkOutput("resetKeptBeat0", got, 32'hC0DE_0000);
    wrBuf[0] = 32'h7777_8888;
    writeBurst(BASE + 32'h104, 1, 4'hF);
    readBurst(BASE + 32'h100, 2, got);
    checkOutput("afterResetFirst", got, 32'hC0DE_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_ram_responder.md
# burst_ram_responder

On-chip memory target for the shared burst bus: the responder end of the transactions the camera grabber and other bus masters initiate. It decodes a begin-transaction cycle, accepts single or burst writes with byte enables into local RAM, and answers burst reads with a data stream and end-of-transaction. Frame buffers and small CPU-visible buffers live behind it.

## Interface
- baseAddress, 32'h0000_0000: byte address of word 0; aligned to region size
- sizeInWords, 1024: RAM depth, power of two, 16..65536
- writeWaitStates, 0: busyOut cycles inserted after each accepted write beat (0..7)
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- beginTransactionIn  in  1  one-cycle transaction start
- addressDataIn  in  32  address at begin, write data on beats
- endTransactionIn  in  1  master ends or aborts transaction
- byteEnablesIn  in  4  byte enables, valid at begin
- dataValidIn  in  1  write beat valid
- burstSizeIn  in  8  beats minus one, valid at begin
- readNotWriteIn  in  1  1 = read, valid at begin
- addressDataOut  out  32  read data; 0 when not driving
- dataValidOut  out  1  read beat valid
- endTransactionOut  out  1  one-cycle end after last read beat
- busyOut  out  1  write wait state
- busErrorOut  out  1  one-cycle error response

## Operation
- States: IDLE, WRITE, READ_SETUP, READ_BURST, READ_END, ERROR_WAIT.
- IDLE: on beginTransactionIn, hit = addressDataIn[31:log2(sizeInWords)+2] matches baseAddress. Miss: ignore, stay IDLE (another target answers).
- On hit, latch word index, byteEnables, beat count = burstSizeIn+1, direction.
- Error if addressDataIn[1:0] != 0, or index + burstSizeIn > sizeInWords-1 (no wrap): busErrorOut=1 next cycle, go ERROR_WAIT; no RAM access.
- WRITE: each cycle with dataValidIn=1 and busyOut=0 writes addressDataIn to RAM[index] under latched byte enables, index+1, count-1. After writeWaitStates>0, busyOut=1 for that many cycles after the beat. Beats beyond count are discarded. endTransactionIn -> IDLE.
- READ_SETUP: present index to RAM. READ_BURST: one beat per cycle, dataValidOut=1, addressDataOut=RAM word, index+1, count-1. After last beat -> READ_END: endTransactionOut=1 for one cycle -> IDLE.
- endTransactionIn during READ_SETUP/READ_BURST: abort, outputs 0 next cycle, no endTransactionOut, -> IDLE.
- ERROR_WAIT: ignore everything until endTransactionIn -> IDLE.
- beginTransactionIn outside IDLE is ignored.
- All outputs 0 whenever not actively asserted (wired-OR bus).
- Reset: state IDLE, every output 0, counters 0; RAM contents unspecified, not cleared.

## Timing
- Begin sampled at cycle T.
- Read: first dataValidOut at T+2, beat k at T+2+k, endTransactionOut at T+2+N (N = beats).
- Write: beat accepted in cycle C is readable by a read begun at C+1.
- Write wait: beat accepted at C -> busyOut high C+1..C+writeWaitStates; next beat accepted no earlier than C+1+writeWaitStates.
- Error: busErrorOut at T+1 only.
- Abort: endTransactionIn at cycle A -> dataValidOut=0 from A+1.
- Reset mid-transaction: outputs 0 next cycle; a partial write keeps beats already written.
- burstSizeIn=0 is a single beat; 255 is 256 beats.

## Structure
- Package: state encoding, region-hit and bounds-check helper constants (address index width derived from sizeInWords).
- One sub-module: byte_enable_ram, single-port synchronous RAM, 32-bit, four per-byte write enables, 1-cycle read latency.
- Controller FSM, counters and bus output registers in the top module.

## Test plan
- Write 4 beats 0x11111111..0x44444444 at baseAddress+0x10, BE=4'hF, then read 4 at same address -> same data at T+2..T+5, endTransactionOut at T+6.
- Single write 0xAABBCCDD with BE=4'b0101 over 0xFFFFFFFF -> readback 0xFFBBFFDD.
- writeWaitStates=2, 3-beat write -> busyOut high 2 cycles after each beat, all 3 words correct, no beat lost while master holds data.
- Read at baseAddress+0x2 or burst of 16 starting at last word-8 -> busErrorOut at T+1 only, RAM untouched, ERROR_WAIT until endTransactionIn.
- Begin at address outside region -> all outputs stay 0, RAM unchanged.
- 16-beat read aborted by endTransactionIn after beat 5, then reset asserted during a later write -> outputs 0 next cycle, no endTransactionOut, next transaction works normally.
